sync_edge_filter: RTL and testbench
===================================

// Module: sync_edge_filter
// PURPOSE
//   Multi-channel synchroniser, glitch filter and edge detector for asynchronous
//   level inputs (GPIO, external IRQ lines, straps) entering a single clock domain.
//   Per channel: N-stage synchroniser, consecutive-sample debounce filter, registered
//   stable level, one-cycle rise/fall pulses and a per-channel selectable event output.
// PARAMETERS
//   NumChannels  default 8   number of independent channels (>=1)
//   SyncStages   default 2   synchroniser flops per channel (>=2)
//   FilterCycles default 3   extra consecutive enabled cycles a new level must persist (0 = no filter)
//   ResetValue   default '0  [NumChannels-1:0] reset level of sync chain and stable_o
// PORTS
//   clk_i       in   1              clock
//   rst_i       in   1              reset, synchronous, active-high
//   en_i        in   1              sample enable; low freezes all state
//   serial_i    in   NumChannels    asynchronous level inputs
//   mode_i      in   2*NumChannels  per-channel event select (edge_mode_e)
//   clr_i       in   NumChannels    pending clear (used only with SYNC_EDGE_FILTER_STICKY_EN)
//   stable_o    out  NumChannels    filtered, synchronised level
//   r_edge_o    out  NumChannels    one-cycle pulse, stable_o went 0->1
//   f_edge_o    out  NumChannels    one-cycle pulse, stable_o went 1->0
//   event_o     out  NumChannels    r/f pulse gated by mode_i
//   pending_o   out  NumChannels    sticky event flags (0 without macro)
// BEHAVIOUR
//   - Reset (rst_i=1 at posedge): sync chain and stable_o <= ResetValue, counters <= 0,
//     r_edge_o/f_edge_o/pending_o <= 0; rst_i wins over en_i. Mid-operation reset
//     aborts any partial filter count; no edge pulse is generated by reset.
//   - en_i=1: sync chain shifts serial_i in each posedge; sync_last = final stage.
//   - Filter per channel: mismatch = (sync_last != stable_q).
//     mismatch && cnt==FilterCycles -> stable_q flips, cnt <= 0, edge pulse set.
//     mismatch && cnt< FilterCycles -> cnt++.  no mismatch -> cnt <= 0 (bounce restarts).
//     cnt width = $clog2(FilterCycles+1), min 1; never wraps.
//   - Latency: input steady before enabled edge 1 -> stable_o changes after edge
//     SyncStages+FilterCycles+1 (FilterCycles=0, SyncStages=2 -> 3 edges).
//   - r_edge_o/f_edge_o registered, high exactly in the cycle stable_o shows the new
//     level; deasserted next edge. Never both high on one channel.
//   - en_i=0: sync, cnt, stable_q hold; r_edge_o/f_edge_o/event_o forced 0 next edge.
//   - event_o = (mode==RISE & r) | (mode==FALL & f) | (mode==BOTH & (r|f)); NONE -> 0.
//     mode_i is sampled combinationally, may change any cycle.
// CONFIGURATION
//   SYNC_EDGE_FILTER_STICKY_EN defined: pending_o[i] set on event_o[i], cleared by
//     clr_i[i] at posedge; simultaneous set and clear -> stays set; holds when en_i=0.
//   Not defined: pending_o tied 0, clr_i ignored, no pending flops instantiated.
// STRUCTURE
//   sync_edge_pkg: typedef enum logic [1:0] edge_mode_e {EDGE_NONE=0, EDGE_RISE=1,
//     EDGE_FALL=2, EDGE_BOTH=3}; shared SyncStages/FilterCycles minimum constants.
//   Sub-module sync_edge_filter_chan: one channel (sync chain, counter, stable, edges,
//     optional pending); top generates NumChannels instances and packs vectors.
//   Top-level parameter assertions: SyncStages>=2, NumChannels>=1.
// TESTING
//   1 S=2,F=3: ch0 0->1 held, en_i=1 -> stable_o[0] high after edge 6; r_edge_o[0] one cycle at 6.
//   2 F=3: ch1 pulse high 3 cycles then low -> stable_o[1] stays 0, no r/f pulse, cnt back to 0.
//   3 en_i low 5 cycles mid-count after ch0 rise -> state frozen; resumes, total enabled edges still 6.
//   4 mode_i ch2=FALL, ch3=BOTH; toggle both 1->0 -> event_o[2] and [3] pulse, r-only toggle -> only [3].
//   5 Sticky build: event on ch4, clr_i[4] same cycle as new event -> pending_o[4] stays 1; clr alone -> 0.
//   6 ResetValue=8'hFF, serial_i=8'hFF, rst_i pulse mid-count -> stable_o=FF, no f/r pulses after reset.

Source files
------------

// File: rtl/sync_edge_filter_pkg.sv
// sync_edge_pkg: shared event-mode encoding and parameter limits for sync_edge_filter
package sync_edge_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_BOTH = 2'd3
    } edge_mode_e;

    localparam int MIN_SYNC_STAGES   = 2;
    localparam int MIN_FILTER_CYCLES = 0;
    localparam int MIN_CHANNELS      = 1;

    // Counter must hold 0..FilterCycles; a zero-length filter still needs one bit.
    function automatic int cnt_width(input int filter_cycles);
        return (filter_cycles > 0) ? $clog2(filter_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/sync_edge_filter_chan.sv
// sync_edge_filter_chan: one channel - synchroniser, debounce counter, stable level, edge pulses, optional sticky flag (SYNC_EDGE_FILTER_STICKY_EN)
module sync_edge_filter_chan
    import sync_edge_pkg::*;
#(
    parameter int   SyncStages   = 2,
    parameter int   FilterCycles = 3,
    parameter logic ResetLevel   = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       serial_i,
    input  edge_mode_e mode_i,
    input  logic       clr_i,
    output logic       stable_o,
    output logic       r_edge_o,
    output logic       f_edge_o,
    output logic       event_o,
    output logic       pending_o
);

    localparam int CntW = cnt_width(FilterCycles);

    logic [SyncStages-1:0] sync_q, sync_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  stable_q, stable_d;
    logic                  r_q, r_d, f_q, f_d;
    logic                  mismatch, flip;

    // Next state: a new level must survive FilterCycles extra enabled samples before it is accepted.
    always_comb begin
        mismatch = sync_q[SyncStages-1] != stable_q;
        flip     = mismatch && (cnt_q == CntW'(FilterCycles));
        sync_d   = en_i ? {sync_q[SyncStages-2:0], serial_i} : sync_q;
        cnt_d    = !en_i ? cnt_q : (mismatch && !flip) ? cnt_q + 1'b1 : '0;
        stable_d = (en_i && flip) ? ~stable_q : stable_q;
        r_d      = en_i && flip && !stable_q;
        f_d      = en_i && flip && stable_q;
    end

    // State registers; reset restores the reset level without producing an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= {SyncStages{ResetLevel}};
            cnt_q    <= '0;
            stable_q <= ResetLevel;
            r_q      <= 1'b0;
            f_q      <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            r_q      <= r_d;
            f_q      <= f_d;
        end
    end

    assign stable_o = stable_q;
    assign r_edge_o = r_q;
    assign f_edge_o = f_q;
    assign event_o  = ((mode_i == EDGE_RISE) && r_q) ||
                      ((mode_i == EDGE_FALL) && f_q) ||
                      ((mode_i == EDGE_BOTH) && (r_q || f_q));

`ifdef SYNC_EDGE_FILTER_STICKY_EN
    logic pending_q, pending_d;

    // Sticky flag: a new event beats a simultaneous clear; everything holds while disabled.
    always_comb pending_d = en_i ? (event_o || (pending_q && !clr_i)) : pending_q;

    // Pending register.
    always_ff @(posedge clk_i) begin
        if (rst_i) pending_q <= 1'b0;
        else       pending_q <= pending_d;
    end

    assign pending_o = pending_q;
`else
    // Clear input has no function without the sticky flag.
    logic unused_clr;
    assign unused_clr = clr_i;
    assign pending_o  = 1'b0;
`endif

endmodule

// File: rtl/sync_edge_filter.sv
// sync_edge_filter: multi-channel synchroniser, glitch filter and edge detector (sticky flags via SYNC_EDGE_FILTER_STICKY_EN)
module sync_edge_filter
    import sync_edge_pkg::*;
#(
    parameter int                     NumChannels  = 8,
    parameter int                     SyncStages   = 2,
    parameter int                     FilterCycles = 3,
    parameter logic [NumChannels-1:0] ResetValue   = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic [NumChannels-1:0]   serial_i,
    input  logic [2*NumChannels-1:0] mode_i,
    input  logic [NumChannels-1:0]   clr_i,
    output logic [NumChannels-1:0]   stable_o,
    output logic [NumChannels-1:0]   r_edge_o,
    output logic [NumChannels-1:0]   f_edge_o,
    output logic [NumChannels-1:0]   event_o,
    output logic [NumChannels-1:0]   pending_o
);

    if (SyncStages < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("sync_edge_filter: SyncStages must be >= %0d", MIN_SYNC_STAGES);
    end
    if (NumChannels < MIN_CHANNELS) begin : g_bad_chan
        $error("sync_edge_filter: NumChannels must be >= %0d", MIN_CHANNELS);
    end
    if (FilterCycles < MIN_FILTER_CYCLES) begin : g_bad_filt
        $error("sync_edge_filter: FilterCycles must be >= %0d", MIN_FILTER_CYCLES);
    end

    for (genvar g = 0; g < NumChannels; g++) begin : g_chan
        sync_edge_filter_chan #(
            .SyncStages  (SyncStages),
            .FilterCycles(FilterCycles),
            .ResetLevel  (ResetValue[g])
        ) u_chan (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .en_i     (en_i),
            .serial_i (serial_i[g]),
            .mode_i   (edge_mode_e'(mode_i[2*g +: 2])),
            .clr_i    (clr_i[g]),
            .stable_o (stable_o[g]),
            .r_edge_o (r_edge_o[g]),
            .f_edge_o (f_edge_o[g]),
            .event_o  (event_o[g]),
            .pending_o(pending_o[g])
        );
    end

endmodule

// File: tb/tb_sync_edge_filter.sv
// tb_sync_edge_filter: directed checks of latency, debounce, enable freeze, event modes, sticky flags and reset level
module tb_sync_edge_filter;

    logic        clk_i = 1'b0;
    logic        rst_a, en_a, rst_b, en_b;
    logic [7:0]  serial_a, serial_b, clr_a, clr_b;
    logic [15:0] mode_a, mode_b;
    logic [7:0]  stable_a, r_a, f_a, event_a, pending_a;
    logic [7:0]  stable_b, r_b, f_b, event_b, pending_b;
    int          errors = 0;
    int          checks = 0;
    logic        sticky;

    always #5 clk_i = ~clk_i;

    sync_edge_filter u_dut_a (
        .clk_i(clk_i), .rst_i(rst_a), .en_i(en_a), .serial_i(serial_a), .mode_i(mode_a),
        .clr_i(clr_a), .stable_o(stable_a), .r_edge_o(r_a), .f_edge_o(f_a),
        .event_o(event_a), .pending_o(pending_a)
    );

    sync_edge_filter #(.ResetValue(8'hFF)) u_dut_b (
        .clk_i(clk_i), .rst_i(rst_b), .en_i(en_b), .serial_i(serial_b), .mode_i(mode_b),
        .clr_i(clr_b), .stable_o(stable_b), .r_edge_o(r_b), .f_edge_o(f_b),
        .event_o(event_b), .pending_o(pending_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
`ifdef SYNC_EDGE_FILTER_STICKY_EN
        sticky = 1'b1;
`else
        sticky = 1'b0;
`endif
        rst_a = 1'b1; en_a = 1'b1; serial_a = '0; mode_a = '0; clr_a = '0;
        rst_b = 1'b1; en_b = 1'b1; serial_b = 8'hFF; mode_b = '0; clr_b = '0;
        step();
        check("rst_stable", stable_a, 8'h00);
        check("rst_edges", {r_a, f_a}, 16'h0);
        check("rst_pending", pending_a, 8'h00);
        check("rstb_stable", stable_b, 8'hFF);
        rst_a = 1'b0;

        // ch0 rise: accepted on the 6th edge, one-cycle rise pulse
        serial_a[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("t1_stable", stable_a[0], k >= 6);
            check("t1_redge", r_a[0], k == 6);
        end
        check("t1_event_none", event_a[0], 1'b0);
        step();
        check("t1_redge_off", r_a[0], 1'b0);
        check("t1_hold", stable_a[0], 1'b1);
        check("t1_fedge", f_a[0], 1'b0);

        // ch1 three-cycle glitch is rejected
        serial_a[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 3) serial_a[1] = 1'b0;
            check("t2_stable", stable_a[1], 1'b0);
            check("t2_edges", {r_a[1], f_a[1]}, 2'b00);
        end
        // counter restarted: a persistent level takes the full latency
        serial_a[1] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("t2_rise", {stable_a[1], r_a[1]}, {k >= 6, k == 6});
        end
        serial_a[1] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("t2_fall", {stable_a[1], f_a[1], r_a[1]}, {k < 6, k == 6, 1'b0});
        end

        // ch0 fall with a 5-cycle enable pause in the middle of the count
        serial_a[0] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("t3_pre", stable_a[0], 1'b1);
        end
        en_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t3_frozen", {stable_a[0], f_a[0]}, 2'b10);
        end
        en_a = 1'b1;
        for (int k = 4; k <= 6; k++) begin
            step();
            check("t3_post", {stable_a[0], f_a[0]}, {k < 6, k == 6});
        end

        // ch2=FALL, ch3=BOTH, ch4=BOTH
        mode_a[5:4] = 2'd2; mode_a[7:6] = 2'd3; mode_a[9:8] = 2'd3;
        serial_a[3:2] = 2'b11;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("t4_rise_ev", event_a[3:2], (k == 6) ? 2'b10 : 2'b00);
        end
        mode_a[7:6] = 2'd0;
        #1;
        check("t4_mode_comb", event_a[3], 1'b0);
        mode_a[7:6] = 2'd3;
        #1;
        check("t4_mode_back", event_a[3], 1'b1);
        en_a = 1'b0;
        step();
        check("t4_en_kill", {r_a[3:2], event_a[3:2]}, 4'b0000);
        en_a = 1'b1;
        serial_a[3:2] = 2'b00;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("t4_fall_ev", event_a[3:2], (k == 6) ? 2'b11 : 2'b00);
        end

        // ch4 sticky flag: set, set+clear, clear alone
        serial_a[4] = 1'b1;
        for (int k = 1; k <= 6; k++) step();
        check("t5_ev_rise", event_a[4], 1'b1);
        step();
        check("t5_set", pending_a[4], sticky);
        serial_a[4] = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        check("t5_ev_fall", event_a[4], 1'b1);
        clr_a[4] = 1'b1;
        step();
        check("t5_set_clr", pending_a[4], sticky);
        step();
        check("t5_clr", pending_a[4], 1'b0);
        clr_a[4] = 1'b0;

        // ResetValue=FF: mid-count reset aborts, no pulses, full latency afterwards
        rst_b = 1'b0;
        step();
        check("t6_idle", {stable_b, r_b, f_b}, 24'hFF0000);
        serial_b = 8'h00;
        for (int k = 1; k <= 3; k++) step();
        check("t6_midcount", stable_b, 8'hFF);
        rst_b = 1'b1;
        serial_b = 8'hFF;
        step();
        check("t6_rst", {stable_b, r_b, f_b}, 24'hFF0000);
        rst_b = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("t6_quiet", {stable_b, r_b, f_b}, 24'hFF0000);
        end
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        serial_b = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("t6_relatch", {stable_b, f_b}, (k >= 6) ? 16'h00FF : 16'hFF00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
